// File: rtl/hsv_ctrl_pkg.sv
// Shared mode/target codes and default timing for the HSV button controller.
// Imported by btn_debounce and hsv_mode_ctrl.
package hsv_ctrl_pkg;

  typedef enum logic [3:0] {
    MODE_OFF      = 4'd0,
    MODE_HUE_SLOW = 4'd1,
    MODE_HUE_FAST = 4'd2,
    MODE_HUE_ADJ  = 4'd3,
    MODE_VAL_ADJ  = 4'd4,
    MODE_SAT_ADJ  = 4'd5
  } mode_e;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_HUE  = 2'd1,
    TGT_VAL  = 2'd2,
    TGT_SAT  = 2'd3
  } tgt_e;

  localparam int DEF_DEB_CYCLES = 200000;
  localparam int DEF_P_SLOW     = 9999999;
  localparam int DEF_P_FAST     = 499999;
  localparam int DEF_P_MED      = 999999;
  localparam int CNT_W          = 24;

  // Out-of-range codes (6..15) wrap to OFF like mode 5 does.
  function automatic logic [3:0] mode_next(input logic [3:0] m);
    return (m >= MODE_SAT_ADJ) ? MODE_OFF : m + 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-time debounce for one raw button.
// Ports: clk, reset (sync, active-high), btn_i raw input, level_o debounced level.
module btn_debounce
  import hsv_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic [1:0]    vld_q, vld_d;
  logic          arm_q, arm_d;
  logic          lvl_q, lvl_d;
  logic          in_eff;
  logic [CW-1:0] cnt_q, cnt_d;

  // A button held through reset stays masked until it is seen released
  // once the synchronizer has refilled.
  always_comb begin
    vld_d  = {vld_q[0], 1'b1};
    arm_d  = arm_q | (vld_q[1] & ~s2_q);
    in_eff = s2_q & arm_q;
    lvl_d  = lvl_q;
    cnt_d  = '0;
    if (in_eff != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = in_eff;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      vld_q <= '0;
      arm_q <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      vld_q <= vld_d;
      arm_q <= arm_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign level_o = lvl_q;

endmodule

// File: rtl/hsv_mode_ctrl.sv
// Mode sequencer and step-rate generator for the HSV colour datapath.
// Ports: clk, reset, btn_mode/btn_adj/dir_sw raw in; mode, mode_chg, step, step_dir, step_tgt, adj_led out.
module hsv_mode_ctrl
  import hsv_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int P_SLOW     = DEF_P_SLOW,
  parameter int P_FAST     = DEF_P_FAST,
  parameter int P_MED      = DEF_P_MED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_adj,
  input  logic       dir_sw,
  output logic [3:0] mode,
  output logic       mode_chg,
  output logic       step,
  output logic       step_dir,
  output logic [1:0] step_tgt,
  output logic       adj_led
);

  localparam logic [CNT_W-1:0] PER_SLOW = CNT_W'(P_SLOW);
  localparam logic [CNT_W-1:0] PER_FAST = CNT_W'(P_FAST);
  localparam logic [CNT_W-1:0] PER_MED  = CNT_W'(P_MED);

  logic             mode_db, adj_db;
  logic             dir_s1_q, dir_s2_q;
  logic             prev_q;
  logic [3:0]       mode_q, mode_d;
  logic             chg_q, chg_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per;
  logic             rise, free_run, adj_mode;
  logic             run, fire, dir_val;
  tgt_e             tgt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_mode),
    .level_o (mode_db)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_adj (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_adj),
    .level_o (adj_db)
  );

  always_comb begin
    per      = '0;
    free_run = 1'b0;
    adj_mode = 1'b0;
    tgt      = TGT_NONE;
    unique case (mode_q)
      MODE_HUE_SLOW: begin
        per = PER_SLOW; free_run = 1'b1; tgt = TGT_HUE;
      end
      MODE_HUE_FAST: begin
        per = PER_FAST; free_run = 1'b1; tgt = TGT_HUE;
      end
      MODE_HUE_ADJ: begin
        per = PER_FAST; adj_mode = 1'b1; tgt = TGT_HUE;
      end
      MODE_VAL_ADJ: begin
        per = PER_MED; adj_mode = 1'b1; tgt = TGT_VAL;
      end
      MODE_SAT_ADJ: begin
        per = PER_MED; adj_mode = 1'b1; tgt = TGT_SAT;
      end
      default: ;
    endcase
  end

  always_comb begin
    rise    = mode_db & ~prev_q;
    mode_d  = mode_q;
    chg_d   = 1'b0;
    if (rise) begin
      mode_d = mode_next(mode_q);
      chg_d  = 1'b1;
    end
    run     = free_run | (adj_mode & adj_db);
    dir_val = adj_mode ? ~dir_s2_q : 1'b1;
    fire    = 1'b0;
    cnt_d   = '0;
    // A mode edge clears the counter and swallows a coincident step.
    if (!rise && run) begin
      if (cnt_q == per) begin
        fire = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    step_d = fire & ~step_q;
    dir_d  = step_d & dir_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_s1_q <= 1'b0;
      dir_s2_q <= 1'b0;
      prev_q   <= 1'b0;
      mode_q   <= MODE_OFF;
      chg_q    <= 1'b0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      dir_s1_q <= dir_sw;
      dir_s2_q <= dir_s1_q;
      prev_q   <= mode_db;
      mode_q   <= mode_d;
      chg_q    <= chg_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mode     = mode_q;
  assign mode_chg = chg_q;
  assign step     = step_q;
  assign step_dir = dir_q;
  assign step_tgt = tgt;
  assign adj_led  = adj_mode & adj_db;

endmodule

// File: tb/tb_hsv_mode_ctrl.sv
// Directed bench for hsv_mode_ctrl with a step/mode-change scoreboard.
// Expected events are queued with their cycle numbers and popped at negedge.
module tb_hsv_mode_ctrl;

  localparam int DEB = 3;
  localparam int PS  = 9;
  localparam int PF  = 4;
  localparam int PM  = 6;
  localparam int LAT = DEB + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_adj = 1'b0;
  logic       dir_sw = 1'b0;
  logic [3:0] mode;
  logic       mode_chg, step, step_dir, adj_led;
  logic [1:0] step_tgt;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int np = 0;
  int last_chg = 0;
  int press_t = 0;
  int b = 0;

  typedef struct {
    int         t;
    logic       dir;
    logic [1:0] tgt;
  } step_exp_t;

  typedef struct {
    int         t;
    logic [3:0] m;
  } chg_exp_t;

  step_exp_t sq[$];
  chg_exp_t  cq[$];
  step_exp_t se;
  chg_exp_t  ce;

  hsv_mode_ctrl #(
    .DEB_CYCLES (DEB),
    .P_SLOW     (PS),
    .P_FAST     (PF),
    .P_MED      (PM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_adj  (btn_adj),
    .dir_sw   (dir_sw),
    .mode     (mode),
    .mode_chg (mode_chg),
    .step     (step),
    .step_dir (step_dir),
    .step_tgt (step_tgt),
    .adj_led  (adj_led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_free(input int m, input int c, input int e);
    int p;
    if (m == 1) p = PS;
    else if (m == 2) p = PF;
    else return;
    for (int s = c + p + 1; s < e; s += p + 1)
      sq.push_back('{s, 1'b1, 2'd1});
  endtask

  task automatic press_start(input int m, input int gap);
    press_t  = cyc;
    btn_mode = 1'b1;
    last_chg = cyc + LAT;
    np       = cyc + gap;
    cq.push_back('{last_chg, 4'(m)});
    push_free(m, last_chg, last_chg + gap);
  endtask

  task automatic press_end(input int hold);
    wait_until(press_t + hold);
    btn_mode = 1'b0;
  endtask

  task automatic adj_hold(input int p, input logic d,
                          input logic [1:0] tg, input int hold);
    int a, on, off;
    a   = cyc;
    on  = a + DEB + 2;
    off = a + hold + DEB + 2;
    btn_adj = 1'b1;
    for (int s = on + p + 1; s <= off; s += p + 1)
      sq.push_back('{s, d, tg});
    wait_until(on + 2);
    @(negedge clk);
    chk("adj_led_on", 32'(adj_led), 32'd1);
    wait_until(a + hold);
    btn_adj = 1'b0;
    wait_until(off + 2);
    @(negedge clk);
    chk("adj_led_off", 32'(adj_led), 32'd0);
  endtask

  always @(negedge clk) begin
    while (sq.size() != 0 && sq[0].t < cyc) begin
      se = sq.pop_front();
      chk("step_missing_at", 32'(cyc), 32'(se.t));
    end
    if (step === 1'b1) begin
      if (sq.size() == 0) begin
        chk("step_unexpected", 32'(step), 32'd0);
      end else begin
        se = sq.pop_front();
        chk("step_t", 32'(cyc), 32'(se.t));
        chk("step_dir", 32'(step_dir), 32'(se.dir));
        chk("step_tgt", 32'(step_tgt), 32'(se.tgt));
      end
    end
    while (cq.size() != 0 && cq[0].t < cyc) begin
      ce = cq.pop_front();
      chk("chg_missing_at", 32'(cyc), 32'(ce.t));
    end
    if (mode_chg === 1'b1) begin
      if (cq.size() == 0) begin
        chk("chg_unexpected", 32'(mode_chg), 32'd0);
      end else begin
        ce = cq.pop_front();
        chk("chg_t", 32'(cyc), 32'(ce.t));
        chk("chg_mode", 32'(mode), 32'(ce.m));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_chg", 32'(mode_chg), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_dir", 32'(step_dir), 32'd0);
    chk("rst_tgt", 32'(step_tgt), 32'd0);
    chk("rst_led", 32'(adj_led), 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    dir_sw = 1'b1;
    wait_until(cyc + 4);

    // one-cycle glitch must be ignored
    btn_mode = 1'b1;
    @(posedge clk);
    #1;
    btn_mode = 1'b0;
    wait_until(cyc + 6);

    // mode 1: free-running slow steps
    press_start(1, 46);
    press_end(10);
    wait_until(np);

    // mode 2, leaving with the counter at its period
    press_start(2, 25);
    press_end(8);
    wait_until(np);

    press_start(3, 16);
    wait_until(last_chg);
    @(negedge clk);
    chk("edge_step", 32'(step), 32'd0);
    chk("edge_mode", 32'(mode), 32'd3);
    chk("edge_cnt", 32'(dut.cnt_q), 32'd0);
    chk("m3_tgt", 32'(step_tgt), 32'd1);
    press_end(8);
    wait_until(np);

    // mode 4: adjust held, dir_sw=1 -> decrement
    press_start(4, 60);
    press_end(8);
    wait_until(press_t + 12);
    chk("m4_tgt", 32'(step_tgt), 32'd2);
    adj_hold(PM, 1'b0, 2'd3 - 2'd1, 30);
    wait_until(np);

    press_start(5, 40);
    press_end(8);
    wait_until(press_t + 10);
    adj_hold(PM, 1'b0, 2'd3, 12);
    wait_until(np);

    press_start(0, 16);
    press_end(8);
    wait_until(np);
    chk("wrap_mode", 32'(mode), 32'd0);

    for (int m = 1; m <= 5; m++) begin
      press_start(m, 16);
      press_end(8);
      if (m < 5) wait_until(np);
    end

    // reset mid-count in mode 5, both buttons held through it
    b = last_chg + 4;
    wait_until(b);
    btn_adj = 1'b1;
    wait_until(b + 8);
    btn_mode = 1'b1;
    wait_until(b + 9);
    reset = 1'b1;
    wait_until(b + 10);
    @(negedge clk);
    chk("mr_mode", 32'(mode), 32'd0);
    chk("mr_chg", 32'(mode_chg), 32'd0);
    chk("mr_step", 32'(step), 32'd0);
    chk("mr_dir", 32'(step_dir), 32'd0);
    chk("mr_tgt", 32'(step_tgt), 32'd0);
    chk("mr_led", 32'(adj_led), 32'd0);
    chk("mr_cnt", 32'(dut.cnt_q), 32'd0);
    wait_until(b + 11);
    reset = 1'b0;
    wait_until(b + 31);
    @(negedge clk);
    chk("held_mode", 32'(mode), 32'd0);
    chk("held_led", 32'(adj_led), 32'd0);
    wait_until(cyc + 1);
    btn_mode = 1'b0;
    btn_adj  = 1'b0;
    wait_until(cyc + 10);

    press_start(1, 30);
    press_end(10);
    wait_until(last_chg + 25);
    @(negedge clk);
    chk("sq_empty", 32'(sq.size()), 32'd0);
    chk("cq_empty", 32'(cq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hsv_mode_ctrl.md
HSV_MODE_CTRL -- requirements
Module: hsv_mode_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 200000, debounce stable-time in clk cycles.
REQ-002 SHALL have parameter P_SLOW, default 9999999, step period minus one for mode 1 (1 s at 10 MHz).
REQ-003 SHALL have parameter P_FAST, default 499999, step period minus one for modes 2 and 3 (50 ms).
REQ-004 SHALL have parameter P_MED, default 999999, step period minus one for modes 4 and 5 (100 ms).
REQ-005 SHALL have port clk  in  1  system clock; reset, synchronous, active-high; clock clk.
REQ-006 SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 SHALL have port btn_mode  in  1  raw asynchronous mode button.
REQ-008 SHALL have port btn_adj  in  1  raw asynchronous adjust button.
REQ-009 SHALL have port dir_sw  in  1  raw direction switch; 0 = up, 1 = down.
REQ-010 SHALL have port mode  out  4  current mode, 0..5.
REQ-011 SHALL have port mode_chg  out  1  one-cycle pulse on every mode update.
REQ-012 SHALL have port step  out  1  one-cycle step request to the HSV datapath.
REQ-013 SHALL have port step_dir  out  1  1 = increment, 0 = decrement; valid when step=1.
REQ-014 SHALL have port step_tgt  out  2  0 none, 1 hue, 2 value, 3 saturation.
REQ-015 SHALL have port adj_led  out  1  adjust-active indicator.

Function
REQ-016 SHALL pass btn_mode, btn_adj, dir_sw through two-flop synchronizers.
REQ-017 SHALL change each debounced button level only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-018 SHALL advance mode 0->1->2->3->4->5->0 on the cycle after a debounced btn_mode rising edge, asserting mode_chg that same cycle.
REQ-019 SHALL treat mode values 6..15 as 0 for step generation and advance them to 0 on the next edge.
REQ-020 SHALL drive step_tgt combinationally: mode 0 -> 0; modes 1,2,3 -> 1; mode 4 -> 2; mode 5 -> 3.
REQ-021 SHALL use a 24-bit period counter, cleared on mode_chg, held at 0 in mode 0.
REQ-022 SHALL in modes 1 and 2 count freely; when counter equals the mode period, assert step for one cycle and reload 0.
REQ-023 SHALL in modes 3..5 count only while debounced btn_adj=1; release clears the counter; first step occurs period+1 cycles after debounced press.
REQ-024 SHALL drive step_dir=1 in modes 1,2 and step_dir = NOT synchronized dir_sw in modes 3..5, registered with step.
REQ-025 SHALL suppress step when mode_chg is asserted in the same cycle; mode change wins.
REQ-026 SHALL drive adj_led=1 while mode is 3, 4 or 5 and debounced btn_adj=1, else 0.
REQ-027 SHALL never assert step for two consecutive cycles.

Reset
REQ-028 SHALL on reset set mode=0, mode_chg=0, step=0, step_dir=0, adj_led=0, period counter 0, debounced levels 0, debounce counters 0, synchronizer flops 0.
REQ-029 SHALL, on reset asserted mid-count or mid-press, emit no step until a full period elapses after reset release.
REQ-030 SHALL not detect a mode edge from a button held through reset until released and pressed again.

Structure
REQ-031 SHALL take mode codes, step_tgt codes and default periods from shared package hsv_ctrl_pkg.
REQ-032 SHALL implement synchronizer plus debounce as sub-module btn_debounce, instantiated for btn_mode and btn_adj.

Verification (DEB_CYCLES=3, P_SLOW=9, P_FAST=4, P_MED=6)
REQ-033 SHALL verify: btn_mode pulse 1 cycle, then clean press 10 cycles -> one mode_chg, mode 0->1; the short pulse is ignored.
REQ-034 SHALL verify: mode 1, idle 40 cycles -> step every 10 cycles, step_dir=1, step_tgt=1.
REQ-035 SHALL verify: mode 4, dir_sw=1, btn_adj held 30 cycles -> adj_led=1, step every 7 cycles with step_dir=0, step_tgt=2; release -> adj_led=0 and no steps.
REQ-036 SHALL verify: six mode presses from mode 0 -> sequence 1,2,3,4,5,0 with six mode_chg pulses.
REQ-037 SHALL verify: mode 2 with counter at 4 and mode edge same cycle -> step=0, mode=3, counter 0.
REQ-038 SHALL verify: reset asserted in mode 5 mid-count -> all outputs 0 next cycle, mode=0.
